// File: rtl/apb_memif_xbar.sv
// APB slave that forwards each access to one of NUM_PORTS memory-style target ports.
// Optional WAIT timeout is compiled in with `define APB_MEMIF_TIMEOUT_EN.
module apb_memif_xbar #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_PORTS      = 4,
   parameter int PORT_SEL_LSB   = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                            clk_i,
   input  logic                            srst_i,
   input  logic                            psel_i,
   input  logic                            penable_i,
   input  logic [ADDR_WIDTH-1:0]           paddr_i,
   input  logic                            pwrite_i,
   input  logic [DATA_WIDTH-1:0]           pwdata_i,
   input  logic [DATA_WIDTH/8-1:0]         pstrb_i,
   output logic                            pready_o,
   output logic [DATA_WIDTH-1:0]           prdata_o,
   output logic                            pslverr_o,
   output logic [NUM_PORTS-1:0]            mreq_o,
   output logic [ADDR_WIDTH-1:0]           maddr_o,
   output logic                            mwe_o,
   output logic [DATA_WIDTH-1:0]           mwdata_o,
   output logic [DATA_WIDTH/8-1:0]         mstrb_o,
   input  logic [NUM_PORTS-1:0]            mack_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] mrdata_i,
   input  logic [NUM_PORTS-1:0]            mresp_i
);

   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // Table of which select-field values map to an existing port; avoids a range compare
   function automatic logic [(1<<IW)-1:0] valid_mask();
      logic [(1<<IW)-1:0] m;
      for (int k = 0; k < (1 << IW); k++) m[k] = (k < NUM_PORTS);
      return m;
   endfunction

   localparam logic [(1<<IW)-1:0] VALID_MASK = valid_mask();

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state;
   state_t                state_next;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_next;
   logic [IW-1:0]         sel;
   logic                  write_q;
   logic                  write_next;
   logic                  decode_err;
   logic                  sel_ack;
   logic                  sel_resp;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  go_resp;
   logic                  resp_err;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  timeout;

   assign maddr_o  = paddr_i;
   assign mwe_o    = pwrite_i;
   assign mwdata_o = pwdata_i;
   assign mstrb_o  = pstrb_i;

   assign idx        = paddr_i[PORT_SEL_LSB +: IW];
   assign decode_err = !VALID_MASK[idx];
   assign sel        = (state == S_IDLE) ? idx : idx_q;

   always_comb begin
      sel_ack  = 1'b0;
      sel_resp = 1'b0;
      sel_data = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (int'(sel) == k) begin
            sel_ack  = mack_i[k];
            sel_resp = mresp_i[k];
            sel_data = mrdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef APB_MEMIF_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;

   // Counter sits at zero outside WAIT, so it is already clear on entry
   always_ff @(posedge clk_i) begin
      if (srst_i || state != S_WAIT) wait_cnt <= '0;
      else                           wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next = state;
      idx_next   = idx_q;
      write_next = write_q;
      go_resp    = 1'b0;
      resp_err   = 1'b0;
      resp_data  = '0;
      mreq_o     = '0;
      case (state)
         S_IDLE: begin
            if (psel_i && penable_i) begin
               if (decode_err) begin
                  go_resp    = 1'b1;
                  resp_err   = 1'b1;
                  state_next = S_RESP;
               end else begin
                  for (int k = 0; k < NUM_PORTS; k++) begin
                     if (int'(idx) == k) mreq_o[k] = 1'b1;
                  end
                  idx_next   = idx;
                  write_next = pwrite_i;
                  if (sel_ack) begin
                     go_resp    = 1'b1;
                     resp_err   = sel_resp;
                     resp_data  = pwrite_i ? '0 : sel_data;
                     state_next = S_RESP;
                  end else begin
                     state_next = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            // A real ack wins over a timeout landing in the same cycle
            if (sel_ack) begin
               go_resp    = 1'b1;
               resp_err   = sel_resp;
               resp_data  = write_q ? '0 : sel_data;
               state_next = S_RESP;
            end else if (timeout) begin
               go_resp    = 1'b1;
               resp_err   = 1'b1;
               state_next = S_RESP;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (srst_i) mreq_o = '0;
   end

   // APB response outputs are loaded only on the transition into RESP, zero otherwise
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state     <= S_IDLE;
         idx_q     <= '0;
         write_q   <= 1'b0;
         pready_o  <= 1'b0;
         prdata_o  <= '0;
         pslverr_o <= 1'b0;
      end else begin
         state     <= state_next;
         idx_q     <= idx_next;
         write_q   <= write_next;
         pready_o  <= go_resp;
         prdata_o  <= resp_data;
         pslverr_o <= resp_err;
      end
   end

endmodule
